// File: rtl/hs_enable_ctrl.sv
// hs_enable_ctrl
//   Sequences the high-speed enable for a glitch-free clock switch. Slow
//   (host) mode is entered or left only after a programmable number of
//   synchronised lsclk rising edges, so the switch always sees a settled
//   low-speed clock on either side of the change.
//
// Ports
//   hsclk       in   free-running high-speed clock; all state on rising edge
//   reset_b     in   asynchronous active-low reset
//   lsclk       in   host low-speed clock, sampled as asynchronous data
//   slow_req    in   current CPU access targets slow space
//   cfg_turbo   in   1 permits high-speed operation, 0 forces slow mode
//   hsen        out  registered high-speed enable (1 only in HS)
//   slow_active out  registered, 1 only in LS
//   sw_busy     out  registered, 1 in LS_ENTER and LS_EXIT
//   sw_count    out  registered count of HS->LS_ENTER transitions (wraps)
module hs_enable_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ENTER_EDGES = 2,
   parameter int unsigned EXIT_EDGES  = 2
) (
   input  logic       hsclk,
   input  logic       reset_b,
   input  logic       lsclk,
   input  logic       slow_req,
   input  logic       cfg_turbo,
   output logic       hsen,
   output logic       slow_active,
   output logic       sw_busy,
   output logic [7:0] sw_count
);

   typedef enum logic [1:0] {
      LS,
      LS_EXIT,
      HS,
      LS_ENTER
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ls_last_q;
   logic                   ls_edge;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sw_count_d;
   logic       hsen_d, slow_active_d, sw_busy_d;
   logic       want_slow;

   // lsclk synchroniser plus one history flop for rising-edge detection.
   // All flops clear on reset, so an edge is only reported after release
   // if lsclk is actually high then.
   always_ff @(posedge hsclk or negedge reset_b) begin
      if (!reset_b) begin
         sync_q    <= '0;
         ls_last_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], lsclk};
         ls_last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ls_edge   = sync_q[SYNC_STAGES-1] & ~ls_last_q;
   assign want_slow = slow_req | ~cfg_turbo;

   always_ff @(posedge hsclk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= LS;
         cnt_q       <= '0;
         sw_count    <= '0;
         hsen        <= 1'b0;
         slow_active <= 1'b1;
         sw_busy     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sw_count    <= sw_count_d;
         hsen        <= hsen_d;
         slow_active <= slow_active_d;
         sw_busy     <= sw_busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sw_count_d = sw_count;

      unique case (state_q)
         LS: begin
            if (!want_slow) begin
               state_d = LS_EXIT;
               cnt_d   = 4'(EXIT_EDGES);
            end
         end
         LS_EXIT: begin
            // An abort request wins over an lsclk edge in the same cycle.
            if (want_slow) begin
               state_d = LS;
            end else if (ls_edge) begin
               if (cnt_q == 4'd1) begin
                  state_d = HS;
               end
               cnt_d = cnt_q - 4'd1;
            end
         end
         HS: begin
            if (want_slow) begin
               state_d    = LS_ENTER;
               cnt_d      = 4'(ENTER_EDGES);
               sw_count_d = sw_count + 8'd1;
            end
         end
         LS_ENTER: begin
            if (ls_edge) begin
               if (cnt_q == 4'd1) begin
                  state_d = LS;
               end
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = LS;
         end
      endcase

      // Outputs are decoded from the next state so they register together
      // with the state change and never lag it by a cycle.
      hsen_d        = (state_d == HS);
      slow_active_d = (state_d == LS);
      sw_busy_d     = (state_d == LS_EXIT) || (state_d == LS_ENTER);
   end

endmodule
